intersection_phase_sequencer: RTL
=================================

Name: intersection_phase_sequencer

Overview:
- Timed phase controller for the four-way intersection. It generates the 3-bit phase code that the light-decoding datapath turns into green/yellow/red/left lamp drives.
- Sequences NS and EW through green, yellow, all-red and optional protected-left phases, using per-phase durations derived from the 50 MHz clock.
- Latches left-turn sensor requests, honours an operator hold, and forces a safe all-red on emergency.

Parameters:
- TICKS_PER_SEC, 50000000, clk cycles per one-second tick (benches use 4).
- GREEN_S, 10, green duration in seconds (1..31).
- YELLOW_S, 3, yellow duration in seconds (1..31).
- ALLRED_S, 2, all-red duration in seconds (1..31).
- LEFT_S, 5, protected-left duration in seconds (1..31).

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset  in  1  synchronous, active-high reset.
- ns_left_sensor  in  1  NS left-lane vehicle sensor (GPIO, asynchronous).
- ew_left_sensor  in  1  EW left-lane vehicle sensor (GPIO, asynchronous).
- emergency  in  1  emergency preemption (asynchronous).
- hold  in  1  operator freeze of the phase timer.
- phase  out  3  phase code to the light decoder.
- phase_start  out  1  one-cycle pulse during the first cycle of each new phase.
- secs_left  out  5  whole seconds remaining in the current phase.
- ns_left_req  out  1  latched NS left request.
- ew_left_req  out  1  latched EW left request.

Behaviour:
- Phase codes:
  - 0 NS green
  - 1 NS yellow
  - 2 all-red after NS
  - 3 EW left
  - 4 EW green
  - 5 EW yellow
  - 6 all-red after EW
  - 7 NS left
- Normal sequence:
  - 0→1→2.
  - 2→3 if ew_left_req, else 2→4.
  - 3→4→5→6.
  - 6→7 if ns_left_req, else 6→0.
  - 7→0.
- Durations: 0/4 use GREEN_S, 1/5 use YELLOW_S, 2/6 use ALLRED_S, 3/7 use LEFT_S.
- Reset values (the edge where reset=1):
  - phase=6, secs_left=ALLRED_S, phase_start=0.
  - Both request flags=0; prescaler=0; synchronizers cleared.
  - Reset mid-phase behaves identically.
- Input synchronization: ns_left_sensor, ew_left_sensor and emergency each pass through a 2-flop synchronizer. Logic acts on the synchronized value, so an input asserted before edge N takes effect at edge N+2.
- Prescaler:
  - Counts 0..TICKS_PER_SEC-1.
  - tick=1 when prescaler==TICKS_PER_SEC-1; prescaler then wraps to 0.
  - Prescaler clears to 0 on every phase transition, so every phase lasts exactly duration×TICKS_PER_SEC cycles.
- Timer:
  - On tick with secs_left>1: secs_left decrements.
  - On tick with secs_left==1: transition.
- Transition (single edge):
  - phase←next, secs_left←duration(next), prescaler←0.
  - phase_start=1 for exactly the first cycle of the new phase.
- Request latching:
  - ns_left_req sets when the synced sensor is 1 and phase≠7; clears on the edge that enters phase 7.
  - ew_left_req is the same, using phase 3.
  - Simultaneous set and clear: clear wins.
- Hold: while hold=1 and synced emergency=0, prescaler and secs_left freeze, and no timed transition occurs. Request latching continues during hold.
- Emergency (synced, level), overrides hold:
  - In 0: immediately go to 1, full YELLOW_S.
  - In 4: immediately go to 5, full YELLOW_S.
  - In 3: immediately go to 2.
  - In 7: immediately go to 6.
  - Each forced move resets the prescaler and pulses phase_start.
  - Yellow phases (1, 5) run their normal timing into 2/6.
  - In 2 or 6: prescaler and secs_left hold at their reload value (ALLRED_S); no exit.
  - On release: a fresh full ALLRED_S countdown runs from that point, then the normal next-phase rule applies.
- Emergency never routes through green or left phases.
- secs_left is never 0 outside reset.

Test Plan:
All scenarios use TICKS_PER_SEC=4, GREEN_S=4, YELLOW_S=2, ALLRED_S=1, LEFT_S=3.
1. Release reset, no inputs → phase=6 for 4 cycles, then phase=0, secs_left=4, phase_start high 1 cycle; secs_left decrements every 4 cycles.
2. Free run, no requests → dwell cycles are 0:16, 1:8, 2:4, 4:16, 5:8, 6:4. Phases 3 and 7 never appear; the loop repeats every 56 cycles.
3. 1-cycle pulse on ns_left_sensor during phase 4 → ns_left_req=1 two edges later and stays set. After 6, phase=7 for 12 cycles, ns_left_req=0 from the first cycle of 7, then phase=0.
4. Emergency asserted in phase 0 at secs_left=3 → third edge: phase=1, secs_left=2. Then 8 cycles later phase=2 and holds while emergency=1. Emergency low → synced release, 4 cycles in 2, then 4 (or 3 if ew_left_req).
5. hold=1 for 40 cycles in phase 4 at secs_left=3 → phase, secs_left and prescaler unchanged. Emergency during hold → phase=5 regardless.
6. Reset asserted mid-phase 5 with both requests set → next edge phase=6, secs_left=1, both requests 0, phase_start=0.

Source files
------------

// File: rtl/intersection_phase_sequencer.sv
// -----------------------------------------------------------------------------
// intersection_phase_sequencer
//   Timed phase controller for a four-way intersection. Sequences NS/EW through
//   green, yellow, all-red and optional protected-left phases. It latches
//   left-turn requests, honours an operator hold, and forces a safe all-red on
//   emergency preemption.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous active-high reset
//   ns_left_sensor in   NS left-lane sensor (asynchronous, synchronized here)
//   ew_left_sensor in   EW left-lane sensor (asynchronous, synchronized here)
//   emergency      in   emergency preemption level (asynchronous)
//   hold           in   operator freeze of the phase timer
//   phase          out  3-bit phase code to the light decoder
//   phase_start    out  pulse during the first cycle of each new phase
//   secs_left      out  whole seconds remaining in the current phase
//   ns_left_req    out  latched NS left request
//   ew_left_req    out  latched EW left request
// -----------------------------------------------------------------------------
module intersection_phase_sequencer #(
   parameter int TICKS_PER_SEC = 50000000,
   parameter int GREEN_S       = 10,
   parameter int YELLOW_S      = 3,
   parameter int ALLRED_S      = 2,
   parameter int LEFT_S        = 5
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ns_left_sensor,
   input  logic       ew_left_sensor,
   input  logic       emergency,
   input  logic       hold,
   output logic [2:0] phase,
   output logic       phase_start,
   output logic [4:0] secs_left,
   output logic       ns_left_req,
   output logic       ew_left_req
);

   localparam int             PW        = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICKS_PER_SEC - 1);

   localparam logic [2:0] PH_NS_GRN  = 3'd0;
   localparam logic [2:0] PH_NS_YEL  = 3'd1;
   localparam logic [2:0] PH_NS_RED  = 3'd2;
   localparam logic [2:0] PH_EW_LEFT = 3'd3;
   localparam logic [2:0] PH_EW_GRN  = 3'd4;
   localparam logic [2:0] PH_EW_YEL  = 3'd5;
   localparam logic [2:0] PH_EW_RED  = 3'd6;
   localparam logic [2:0] PH_NS_LEFT = 3'd7;

   logic [2:0]    r_phase;
   logic [4:0]    r_secs;
   logic [PW-1:0] r_presc;
   logic          r_start;
   logic          r_ns_req, r_ew_req;
   logic          r_ns_s1, r_ns_s2, r_ew_s1, r_ew_s2, r_emg_s1, r_emg_s2;

   logic [2:0]    w_phase_nx, w_target;
   logic [4:0]    w_secs_nx;
   logic [PW-1:0] w_presc_nx;
   logic          w_start_nx, w_ns_req_nx, w_ew_req_nx;
   logic          w_tick, w_go, w_run;

   function automatic logic [4:0] f_duration(input logic [2:0] p);
      case (p)
         PH_NS_GRN, PH_EW_GRN:   f_duration = 5'(GREEN_S);
         PH_NS_YEL, PH_EW_YEL:   f_duration = 5'(YELLOW_S);
         PH_NS_RED, PH_EW_RED:   f_duration = 5'(ALLRED_S);
         default:                f_duration = 5'(LEFT_S);
      endcase
   endfunction

   function automatic logic [2:0] f_normal_next(input logic [2:0] p,
                                                input logic       ns_req,
                                                input logic       ew_req);
      case (p)
         PH_NS_GRN:  f_normal_next = PH_NS_YEL;
         PH_NS_YEL:  f_normal_next = PH_NS_RED;
         PH_NS_RED:  f_normal_next = ew_req ? PH_EW_LEFT : PH_EW_GRN;
         PH_EW_LEFT: f_normal_next = PH_EW_GRN;
         PH_EW_GRN:  f_normal_next = PH_EW_YEL;
         PH_EW_YEL:  f_normal_next = PH_EW_RED;
         PH_EW_RED:  f_normal_next = ns_req ? PH_NS_LEFT : PH_NS_GRN;
         default:    f_normal_next = PH_NS_GRN;
      endcase
   endfunction

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_phase  <= PH_EW_RED;
         r_secs   <= 5'(ALLRED_S);
         r_presc  <= '0;
         r_start  <= 1'b0;
         r_ns_req <= 1'b0;
         r_ew_req <= 1'b0;
         r_ns_s1  <= 1'b0;
         r_ns_s2  <= 1'b0;
         r_ew_s1  <= 1'b0;
         r_ew_s2  <= 1'b0;
         r_emg_s1 <= 1'b0;
         r_emg_s2 <= 1'b0;
      end else begin
         r_phase  <= w_phase_nx;
         r_secs   <= w_secs_nx;
         r_presc  <= w_presc_nx;
         r_start  <= w_start_nx;
         r_ns_req <= w_ns_req_nx;
         r_ew_req <= w_ew_req_nx;
         r_ns_s1  <= ns_left_sensor;
         r_ns_s2  <= r_ns_s1;
         r_ew_s1  <= ew_left_sensor;
         r_ew_s2  <= r_ew_s1;
         r_emg_s1 <= emergency;
         r_emg_s2 <= r_emg_s1;
      end
   end

   // Next-state logic
   always_comb begin
      w_tick      = (r_presc == PRESC_MAX);
      w_go        = 1'b0;
      w_run       = 1'b0;
      w_target    = r_phase;
      w_phase_nx  = r_phase;
      w_secs_nx   = r_secs;
      w_presc_nx  = r_presc;

      if (r_emg_s2) begin
         case (r_phase)
            PH_NS_GRN:  begin w_go = 1'b1; w_target = PH_NS_YEL; end
            PH_EW_GRN:  begin w_go = 1'b1; w_target = PH_EW_YEL; end
            PH_EW_LEFT: begin w_go = 1'b1; w_target = PH_NS_RED; end
            PH_NS_LEFT: begin w_go = 1'b1; w_target = PH_EW_RED; end
            // Parked in all-red: keep the timer at its reload value so release
            // starts a fresh full countdown.
            PH_NS_RED, PH_EW_RED: begin
               w_presc_nx = '0;
               w_secs_nx  = 5'(ALLRED_S);
            end
            default:    w_run = 1'b1;   // yellows finish normally, hold ignored
         endcase
      end else if (!hold) begin
         w_run = 1'b1;
      end

      if (w_run) begin
         if (w_tick) begin
            w_presc_nx = '0;
            if (r_secs > 5'd1) begin
               w_secs_nx = r_secs - 5'd1;
            end else begin
               w_go     = 1'b1;
               w_target = f_normal_next(r_phase, r_ns_req, r_ew_req);
            end
         end else begin
            w_presc_nx = r_presc + 1'b1;
         end
      end

      if (w_go) begin
         w_phase_nx = w_target;
         w_secs_nx  = f_duration(w_target);
         w_presc_nx = '0;
      end
      w_start_nx = w_go;

      // Clearing on entry to the served left phase takes priority over a set.
      if (w_go && (w_target == PH_NS_LEFT))
         w_ns_req_nx = 1'b0;
      else if (r_ns_s2 && (r_phase != PH_NS_LEFT))
         w_ns_req_nx = 1'b1;
      else
         w_ns_req_nx = r_ns_req;

      if (w_go && (w_target == PH_EW_LEFT))
         w_ew_req_nx = 1'b0;
      else if (r_ew_s2 && (r_phase != PH_EW_LEFT))
         w_ew_req_nx = 1'b1;
      else
         w_ew_req_nx = r_ew_req;
   end

   // Outputs
   always_comb begin
      phase       = r_phase;
      phase_start = r_start;
      secs_left   = r_secs;
      ns_left_req = r_ns_req;
      ew_left_req = r_ew_req;
   end

endmodule
